// File: rtl/tag_access_assoc.sv
// rtl/tag_access_assoc.sv - N-way set-associative tag store with victim selection and invalidate walker
module tag_access_assoc #(
   parameter int NUM_SETS  = 64,
   parameter int NUM_WAYS  = 4,
   parameter int TAG_WIDTH = 20,
   localparam int SET_BITS = $clog2(NUM_SETS),
   localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          stall,
   input  logic                          lookup,
   input  logic                          lookup_write,
   input  logic                          fill,
   input  logic                          flush,
   input  logic [SET_BITS+TAG_WIDTH-1:0] addr,
   output logic                          ready,
   output logic                          rsp_valid,
   output logic                          tag_match,
   output logic [NUM_WAYS-1:0]           hit_way,
   output logic [NUM_WAYS-1:0]           victim_way,
   output logic                          victim_valid,
   output logic                          victim_dirty,
   output logic [TAG_WIDTH-1:0]          victim_tag
);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_IDLE  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t              state;
   logic [SET_BITS-1:0] walk_cnt;

   // Line storage; deliberately unreset, the walker invalidates it instead.
   logic [TAG_WIDTH-1:0] tag_mem   [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0]  valid_mem [NUM_SETS];
   logic [NUM_WAYS-1:0]  dirty_mem [NUM_SETS];
   logic [WAY_BITS-1:0]  ptr_mem   [NUM_SETS];

   logic [SET_BITS-1:0]  set_idx;
   logic [TAG_WIDTH-1:0] req_tag;

   assign set_idx = addr[SET_BITS-1:0];
   assign req_tag = addr[SET_BITS+TAG_WIDTH-1:SET_BITS];

   logic accept;
   logic do_flush;
   logic do_fill;
   logic do_lookup;

   assign accept    = (state == S_IDLE) && !stall;
   assign do_flush  = accept && flush;
   assign do_fill   = accept && !flush && fill;
   assign do_lookup = accept && !flush && !fill && lookup;

   logic [NUM_WAYS-1:0] hit_vec;
   logic [WAY_BITS-1:0] hit_idx;
   logic                inv_found;
   logic [WAY_BITS-1:0] inv_idx;
   logic [WAY_BITS-1:0] vic_idx;
   logic                set_full;
   logic [WAY_BITS-1:0] ptr_next;

   // Tag compare and victim choice for the addressed set (invalid-first, else round-robin pointer)
   always_comb begin
      hit_vec   = '0;
      hit_idx   = '0;
      inv_found = 1'b0;
      inv_idx   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_mem[set_idx][w] && (tag_mem[set_idx][w] == req_tag)) begin
            hit_vec[w] = 1'b1;
            hit_idx    = WAY_BITS'(w);
         end
      end
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_mem[set_idx][w]) begin
            inv_found = 1'b1;
            inv_idx   = WAY_BITS'(w);
         end
      end
      set_full = !inv_found;
      vic_idx  = inv_found ? inv_idx : ptr_mem[set_idx];
      ptr_next = (NUM_WAYS == 1) ? '0 : ptr_mem[set_idx] + WAY_BITS'(1);
   end

   // Walk controller: INIT after reset and FLUSH on request, one set per cycle, stall does not pause it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_INIT;
         walk_cnt <= '0;
         ready    <= 1'b0;
      end else begin
         case (state)
            S_INIT, S_FLUSH: begin
               walk_cnt <= walk_cnt + SET_BITS'(1);
               if (walk_cnt == SET_BITS'(NUM_SETS - 1)) begin
                  state <= S_IDLE;
                  ready <= 1'b1;
               end
            end
            S_IDLE: begin
               if (do_flush) begin
                  state    <= S_FLUSH;
                  walk_cnt <= '0;
                  ready    <= 1'b0;
               end
            end
            default: begin
               state    <= S_INIT;
               walk_cnt <= '0;
               ready    <= 1'b0;
            end
         endcase
      end
   end

   // Array updates: walk clear, fill install, dirty marking on a write hit
   always_ff @(posedge clk) begin
      if (state != S_IDLE) begin
         valid_mem[walk_cnt] <= '0;
         dirty_mem[walk_cnt] <= '0;
         ptr_mem[walk_cnt]   <= '0;
      end else if (do_fill) begin
         tag_mem[set_idx][vic_idx]   <= req_tag;
         valid_mem[set_idx][vic_idx] <= 1'b1;
         dirty_mem[set_idx][vic_idx] <= 1'b0;
         if (set_full) begin
            ptr_mem[set_idx] <= ptr_next;
         end
      end else if (do_lookup && lookup_write && (|hit_vec)) begin
         dirty_mem[set_idx][hit_idx] <= 1'b1;
      end
   end

   // Registered lookup response; frozen while stalled, victim reflects pre-update state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid    <= 1'b0;
         tag_match    <= 1'b0;
         hit_way      <= '0;
         victim_way   <= '0;
         victim_valid <= 1'b0;
         victim_dirty <= 1'b0;
         victim_tag   <= '0;
      end else if (!stall) begin
         rsp_valid <= do_lookup;
         if (do_lookup) begin
            tag_match    <= |hit_vec;
            hit_way      <= hit_vec;
            victim_way   <= NUM_WAYS'(1) << vic_idx;
            victim_valid <= valid_mem[set_idx][vic_idx];
            victim_dirty <= dirty_mem[set_idx][vic_idx];
            victim_tag   <= tag_mem[set_idx][vic_idx];
         end
      end
   end

endmodule

// File: tb/tb_tag_access_assoc.sv
// tb/tb_tag_access_assoc.sv - directed self-checking bench with behavioural cache-tag model
module tb_tag_access_assoc;

   localparam int NS = 64;
   localparam int NW = 4;
   localparam int TW = 20;
   localparam int SB = 6;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          stall = 1'b0;
   logic          lookup = 1'b0;
   logic          lookup_write = 1'b0;
   logic          fill = 1'b0;
   logic          flush = 1'b0;
   logic [SB+TW-1:0] addr = '0;
   logic          ready;
   logic          rsp_valid;
   logic          tag_match;
   logic [NW-1:0] hit_way;
   logic [NW-1:0] victim_way;
   logic          victim_valid;
   logic          victim_dirty;
   logic [TW-1:0] victim_tag;

   int checks = 0;
   int errors = 0;

   tag_access_assoc #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_WIDTH(TW)) dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .lookup(lookup),
      .lookup_write(lookup_write), .fill(fill), .flush(flush), .addr(addr),
      .ready(ready), .rsp_valid(rsp_valid), .tag_match(tag_match), .hit_way(hit_way),
      .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
      .victim_tag(victim_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: whole-set state per line, walk modelled as a countdown
   int m_tag   [NS][NW];
   bit m_valid [NS][NW];
   bit m_dirty [NS][NW];
   int m_ptr   [NS];
   int walk_left;
   bit e_ready, e_rsp_valid, e_match, e_vvalid, e_vdirty;
   int e_hit, e_vway, e_vtag;

   function automatic void clear_all();
      for (int s = 0; s < NS; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < NW; w++) begin
            m_valid[s][w] = 0;
            m_dirty[s][w] = 0;
         end
      end
   endfunction

   function automatic int pick_victim(int s);
      for (int w = 0; w < NW; w++)
         if (!m_valid[s][w]) return w;
      return m_ptr[s];
   endfunction

   initial begin
      int s, t, v, hw;
      bit full;
      walk_left = NS;
      e_ready = 0; e_rsp_valid = 0; e_match = 0; e_vvalid = 0; e_vdirty = 0;
      e_hit = 0; e_vway = 0; e_vtag = 0;
      clear_all();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            walk_left = NS;
            clear_all();
            e_ready = 0; e_rsp_valid = 0; e_match = 0; e_vvalid = 0; e_vdirty = 0;
            e_hit = 0; e_vway = 0; e_vtag = 0;
         end else begin
            s = int'(addr[SB-1:0]);
            t = int'(addr[SB+TW-1:SB]);
            if (walk_left > 0) begin
               walk_left--;
               if (!stall) e_rsp_valid = 0;
            end else if (!stall) begin
               if (flush) begin
                  clear_all();
                  walk_left = NS;
                  e_rsp_valid = 0;
               end else if (fill) begin
                  full = 1;
                  for (int w = 0; w < NW; w++) if (!m_valid[s][w]) full = 0;
                  v = pick_victim(s);
                  m_tag[s][v] = t;
                  m_valid[s][v] = 1;
                  m_dirty[s][v] = 0;
                  if (full) m_ptr[s] = (m_ptr[s] + 1) % NW;
                  e_rsp_valid = 0;
               end else if (lookup) begin
                  hw = -1;
                  for (int w = 0; w < NW; w++)
                     if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
                  v = pick_victim(s);
                  e_rsp_valid = 1;
                  e_match = (hw >= 0);
                  e_hit = (hw >= 0) ? (1 << hw) : 0;
                  e_vway = 1 << v;
                  e_vvalid = m_valid[s][v];
                  e_vdirty = m_dirty[s][v];
                  e_vtag = m_tag[s][v];
                  if (lookup_write && hw >= 0) m_dirty[s][hw] = 1;
               end else begin
                  e_rsp_valid = 0;
               end
            end
            e_ready = (walk_left == 0);
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         chk("cyc_ready", 32'(ready), 32'(e_ready));
         chk("cyc_rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
         chk("cyc_tag_match", 32'(tag_match), 32'(e_match));
         chk("cyc_hit_way", 32'(hit_way), 32'(e_hit));
         chk("cyc_victim_way", 32'(victim_way), 32'(e_vway));
         chk("cyc_victim_valid", 32'(victim_valid), 32'(e_vvalid));
         chk("cyc_victim_dirty", 32'(victim_dirty), 32'(e_vdirty));
         if (e_vvalid) chk("cyc_victim_tag", 32'(victim_tag), 32'(e_vtag));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SB+TW-1:0] mk(int t, int s);
      return {TW'(t), SB'(s)};
   endfunction

   task automatic do_fill(int t, int s);
      fill = 1; addr = mk(t, s);
      tick();
      fill = 0;
   endtask

   task automatic lk(input string nm, input int t, input int s, input bit wr,
                     input bit em, input int eh, input int evw, input bit evv,
                     input bit evd, input int evt);
      lookup = 1; lookup_write = wr; addr = mk(t, s);
      tick();
      lookup = 0; lookup_write = 0;
      chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, "_match"}, 32'(tag_match), 32'(em));
      chk({nm, "_hit_way"}, 32'(hit_way), 32'(eh));
      chk({nm, "_victim_way"}, 32'(victim_way), 32'(evw));
      chk({nm, "_victim_valid"}, 32'(victim_valid), 32'(evv));
      chk({nm, "_victim_dirty"}, 32'(victim_dirty), 32'(evd));
      if (evv) chk({nm, "_victim_tag"}, 32'(victim_tag), 32'(evt));
   endtask

   task automatic count_walk(input string nm);
      int n;
      n = 0;
      while (!ready && n < 200) begin
         tick();
         n++;
      end
      chk({nm, "_ready_low_cycles"}, 32'(n), 32'd64);
   endtask

   initial begin
      tick(); tick();
      chk("reset_ready", 32'(ready), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      reset_n = 1;
      count_walk("init");

      lk("first", 'h123, 5, 0, 0, 'b0000, 'b0001, 0, 0, 0);

      do_fill('hA, 5); do_fill('hB, 5); do_fill('hC, 5); do_fill('hD, 5);
      lk("hitA", 'hA, 5, 0, 1, 'b0001, 'b0001, 1, 0, 'hA);
      lk("hitB", 'hB, 5, 0, 1, 'b0010, 'b0001, 1, 0, 'hA);
      lk("hitC", 'hC, 5, 0, 1, 'b0100, 'b0001, 1, 0, 'hA);
      lk("hitD", 'hD, 5, 0, 1, 'b1000, 'b0001, 1, 0, 'hA);
      lk("missE", 'hE, 5, 0, 0, 'b0000, 'b0001, 1, 0, 'hA);

      do_fill('hE, 5);
      lk("hitE", 'hE, 5, 0, 1, 'b0001, 'b0010, 1, 0, 'hB);
      lk("missA", 'hA, 5, 0, 0, 'b0000, 'b0010, 1, 0, 'hB);

      lk("wrB", 'hB, 5, 1, 1, 'b0010, 'b0010, 1, 0, 'hB);
      lk("missF", 'hF, 5, 0, 0, 'b0000, 'b0010, 1, 1, 'hB);
      do_fill('hF, 5);
      lk("hitF", 'hF, 5, 0, 1, 'b0010, 'b0100, 1, 0, 'hC);
      do_fill('h10, 5); do_fill('h11, 5); do_fill('h12, 5);
      lk("clean_w1", 'h13, 5, 0, 0, 'b0000, 'b0010, 1, 0, 'hF);

      lk("pre_stall", 'hF, 5, 0, 1, 'b0010, 'b0010, 1, 0, 'hF);
      stall = 1; lookup = 1; fill = 1; addr = mk('h99, 5);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_hit_way", 32'(hit_way), 32'b0010);
         chk("stall_victim_tag", 32'(victim_tag), 32'hF);
      end
      stall = 0; lookup = 0; fill = 0;
      lk("post_stall", 'h99, 5, 0, 0, 'b0000, 'b0010, 1, 0, 'hF);
      lk("post_stall_hit", 'h12, 5, 0, 1, 'b0001, 'b0010, 1, 0, 'hF);

      fill = 1; lookup = 1; addr = mk('h20, 7);
      tick();
      fill = 0; lookup = 0;
      chk("prio_no_rsp", 32'(rsp_valid), 32'd0);
      lk("prio_fill_done", 'h20, 7, 0, 1, 'b0001, 'b0010, 0, 0, 0);

      flush = 1; lookup = 1; addr = mk('hE, 5);
      tick();
      flush = 0; lookup = 0;
      chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
      count_walk("flush");
      lk("flushed_E", 'hE, 5, 0, 0, 'b0000, 'b0001, 0, 0, 0);
      lk("flushed_20", 'h20, 7, 0, 0, 'b0000, 'b0001, 0, 0, 0);

      flush = 1;
      tick();
      flush = 0;
      for (int i = 0; i < 30; i++) tick();
      chk("midwalk_ready", 32'(ready), 32'd0);
      reset_n = 0;
      #2;
      chk("midreset_ready", 32'(ready), 32'd0);
      tick();
      reset_n = 1;
      count_walk("rewalk");
      lk("after_rewalk", 'h123, 5, 0, 0, 'b0000, 'b0001, 0, 0, 0);

      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
